// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Summary  : Two-requester arbiter time-sharing one external ALU; multi-cycle MUL.
//            Optional macro ALU_ARB_RR_EN selects round-robin instead of fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [3:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [3:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_zero_o,
  output logic [3:0]  alu_ctrl_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  input  logic [31:0] alu_data_i
);

  localparam logic [3:0] c_ctrl_or   = 4'd0;
  localparam logic [3:0] c_ctrl_and  = 4'd1;
  localparam logic [3:0] c_ctrl_add  = 4'd2;
  localparam logic [3:0] c_ctrl_sub  = 4'd3;
  localparam logic [3:0] c_ctrl_mul  = 4'd4;
  localparam logic [3:0] c_ctrl_addi = 4'd5;
  localparam logic [3:0] c_ctrl_lw   = 4'd6;
  localparam logic [3:0] c_ctrl_sw   = 4'd7;
  localparam logic [3:0] c_ctrl_beq  = 4'd8;
  localparam logic [3:0] c_mul_last  = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic        r_owner;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b;
  logic [31:0] r_result;
  logic        r_zero;
  logic [3:0]  r_cnt;
  logic        w_gnt0, w_gnt1, w_capture, w_rsp_ready, w_is_mul, w_legal;
  logic [31:0] w_result;

  assign w_is_mul    = (r_op == c_ctrl_mul);
  assign w_rsp_ready = r_owner ? rsp1_ready_i : rsp0_ready_i;

  always_comb begin
    case (r_op)
      c_ctrl_or, c_ctrl_and, c_ctrl_add, c_ctrl_sub, c_ctrl_mul,
      c_ctrl_addi, c_ctrl_lw, c_ctrl_sw, c_ctrl_beq: w_legal = 1'b1;
      default:                                       w_legal = 1'b0;
    endcase
  end

  // Illegal op codes never expose whatever the ALU happens to return.
  assign w_result = w_legal ? alu_data_i : 32'd0;

`ifdef ALU_ARB_RR_EN
  logic r_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_ptr <= w_gnt0;
    end
  end
`endif

  always_comb begin
    w_next    = r_state;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst_i) begin
          if (req0_valid_i && req1_valid_i) begin
`ifdef ALU_ARB_RR_EN
            w_gnt0 = ~r_ptr;
            w_gnt1 = r_ptr;
`else
            w_gnt0 = 1'b1;
`endif
          end else begin
            w_gnt0 = req0_valid_i;
            w_gnt1 = req1_valid_i;
          end
          if (w_gnt0 || w_gnt1) w_next = EXEC;
        end
      end
      EXEC: begin
        if (!w_is_mul || (r_cnt == c_mul_last)) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        if (w_rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_op     <= 4'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_zero   <= 1'b0;
      r_cnt    <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_gnt0 || w_gnt1) begin
        r_owner <= w_gnt1;
        r_op    <= w_gnt1 ? req1_op_i : req0_op_i;
        r_a     <= w_gnt1 ? req1_a_i  : req0_a_i;
        r_b     <= w_gnt1 ? req1_b_i  : req0_b_i;
        r_cnt   <= 4'd0;
      end else if (r_state == EXEC && !w_capture) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_capture) begin
        r_result <= w_result;
        r_zero   <= (w_result == 32'd0);
      end
    end
  end

  assign req0_ready_o = w_gnt0;
  assign req1_ready_o = w_gnt1;
  assign rsp0_valid_o = (r_state == RESP) && !r_owner;
  assign rsp1_valid_o = (r_state == RESP) &&  r_owner;
  assign rsp_data_o   = r_result;
  assign rsp_zero_o   = r_zero;
  assign alu_ctrl_o   = r_op;
  assign alu_data1_o  = r_a;
  assign alu_data2_o  = r_b;

endmodule

`default_nettype wire
